stereo_view_sched: RTL and testbench

- Frame-synchronous controller for the stereovision output view multiplexer.
- Monitors the input image AXI-Stream (tvalid/tuser/tlast) and tracks pixel-beat and line position within each frame.
- Applies the view selection (passthrough / gray / unfolded L / unfolded R / disparity L / disparity R) only at frame boundaries, so output frames are never torn.
- Adds an auto-cycle mode, frame counting and stream-integrity error flags; drives the view-select input of the top-level stereovision wrapper in place of the raw switch.

---
 rtl/stereo_view_sched_pkg.sv | 23 ++
 rtl/stereo_view_sched_pos_tracker.sv | 61 ++++++
 rtl/stereo_view_sched.sv | 133 +++++++++++++
 tb/tb_stereo_view_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_view_sched_pkg.sv
// Shared types and helpers for the stereovision view scheduler.
package stereo_pkg;

   typedef enum logic [2:0] {
      VIEW_PASS   = 3'd0,
      VIEW_GRAY   = 3'd1,
      VIEW_UNF_L  = 3'd2,
      VIEW_UNF_R  = 3'd3,
      VIEW_DISP_L = 3'd4,
      VIEW_DISP_R = 3'd5
   } view_e;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } sched_state_e;

   function automatic int unsigned beats_per_line(input int unsigned width,
                                                  input int unsigned samples);
      return width / samples;
   endfunction

endpackage

// File: rtl/stereo_view_sched_pos_tracker.sv
// Beat/line position tracking within a monitored AXI-Stream frame,
// with end-of-frame and stream-integrity event detection.
module stream_pos_tracker
   import stereo_pkg::*;
#(
   parameter int unsigned BPL    = 960,
   parameter int unsigned HEIGHT = 2160
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic abort,
   input  logic tvalid,
   input  logic tuser,
   input  logic tlast,
   output logic sof,
   output logic eof,
   output logic err_line,
   output logic err_sof
);

   localparam int unsigned BW = (BPL > 1) ? $clog2(BPL) : 1;
   localparam int unsigned LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BPL - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(HEIGHT - 1);

   logic [BW-1:0] beat;
   logic [LW-1:0] line;
   logic          overrun;
   logic          line_end;

   // overrun marks a last-beat without tlast; the following beat closes the
   // line regardless, so beat never has to count past BPL-1.
   always_comb begin
      sof      = tvalid & tuser & ~active;
      err_sof  = tvalid & tuser & active;
      line_end = tvalid & active & ~tuser & (tlast | overrun);
      err_line = line_end & (overrun | (beat != BEAT_LAST));
      eof      = line_end & (line == LINE_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         beat    <= '0;
         line    <= '0;
         overrun <= 1'b0;
      end else if (sof || err_sof) begin
         beat    <= BW'(1);
         line    <= '0;
         overrun <= 1'b0;
      end else if (line_end) begin
         beat    <= '0;
         overrun <= 1'b0;
         line    <= (line == LINE_LAST) ? '0 : line + LW'(1);
      end else if (tvalid && active) begin
         if (beat == BEAT_LAST) overrun <= 1'b1;
         else                   beat    <= beat + BW'(1);
      end
   end

endmodule

// File: rtl/stereo_view_sched.sv
// Frame-synchronous view-select controller: commits the requested view only
// between frames, with auto-cycle, frame counting and stream error flags.
module stereo_view_sched
   import stereo_pkg::*;
#(
   parameter int unsigned WIDTH                 = 3840,
   parameter int unsigned HEIGHT                = 2160,
   parameter int unsigned MAX_SAMPLES_PER_CLOCK = 4,
   parameter int unsigned NUM_VIEWS             = 6,
   parameter int unsigned AUTO_FRAMES           = 60,
   parameter int unsigned TIMEOUT_CYCLES        = 1048576
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [3:0]  switch_img,
   input  logic        mon_tvalid,
   input  logic        mon_tuser,
   input  logic        mon_tlast,
   output logic [2:0]  view_sel,
   output logic        view_changed,
   output logic [15:0] frame_cnt,
   output logic        in_frame,
   output logic        err_line,
   output logic        err_sof,
   output logic        err_timeout
);

   localparam int unsigned BPL = beats_per_line(WIDTH, MAX_SAMPLES_PER_CLOCK);
   localparam int unsigned IW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned AW  = $clog2(AUTO_FRAMES + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);
   localparam logic [3:0]    NV        = 4'(NUM_VIEWS);

   if (WIDTH % MAX_SAMPLES_PER_CLOCK != 0) begin : g_bpl_check
      $error("WIDTH must be a multiple of MAX_SAMPLES_PER_CLOCK");
   end
   if (AUTO_FRAMES < 1 || TIMEOUT_CYCLES < 2) begin : g_cnt_check
      $error("AUTO_FRAMES must be >= 1 and TIMEOUT_CYCLES >= 2");
   end
   if (NUM_VIEWS < 1 || NUM_VIEWS > 6) begin : g_view_check
      $error("NUM_VIEWS must be in 1..6");
   end

   sched_state_e  state_q, state_d;
   view_e         view_q, pending, manual_view, auto_view_q, auto_view_next;
   logic [IW-1:0] idle_cnt_q;
   logic [AW-1:0] auto_cnt_q;
   logic          auto_en, auto_adv, commit, timeout;
   logic          trk_sof, trk_eof, trk_err_line, trk_err_sof;

   stream_pos_tracker #(
      .BPL    (BPL),
      .HEIGHT (HEIGHT)
   ) u_tracker (
      .clk      (aclk),
      .rst      (areset),
      .active   (state_q == ACTIVE),
      .abort    (timeout),
      .tvalid   (mon_tvalid),
      .tuser    (mon_tuser),
      .tlast    (mon_tlast),
      .sof      (trk_sof),
      .eof      (trk_eof),
      .err_line (trk_err_line),
      .err_sof  (trk_err_sof)
   );

   always_comb begin
      auto_en     = switch_img[3];
      manual_view = VIEW_PASS;
      if ({1'b0, switch_img[2:0]} < NV) manual_view = view_e'(switch_img[2:0]);
      auto_view_next = VIEW_PASS;
      if (({1'b0, auto_view_q} + 4'd1) < NV) auto_view_next = view_e'(auto_view_q + 3'd1);
      // The view advanced at this EOF must be the one committed at this EOF.
      auto_adv = auto_en & trk_eof & (auto_cnt_q == AUTO_LAST);
      pending  = auto_en ? (auto_adv ? auto_view_next : auto_view_q) : manual_view;
      commit   = (state_q == IDLE) | trk_eof;
      timeout  = (state_q == ACTIVE) & ~mon_tvalid & (idle_cnt_q == IDLE_LAST);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (trk_sof) state_d = ACTIVE;
         ACTIVE:  if (trk_eof || timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         view_q       <= VIEW_PASS;
         view_changed <= 1'b0;
         frame_cnt    <= '0;
         err_line     <= 1'b0;
         err_sof      <= 1'b0;
         err_timeout  <= 1'b0;
         idle_cnt_q   <= '0;
         auto_cnt_q   <= '0;
         auto_view_q  <= VIEW_PASS;
      end else begin
         view_changed <= commit && (pending != view_q);
         if (commit) view_q <= pending;
         if (trk_eof) frame_cnt <= frame_cnt + 16'd1;
         err_line    <= trk_err_line;
         err_sof     <= trk_err_sof;
         err_timeout <= timeout;
         if (state_q == ACTIVE && !mon_tvalid && !timeout) idle_cnt_q <= idle_cnt_q + IW'(1);
         else                                              idle_cnt_q <= '0;
         if (!auto_en) begin
            auto_cnt_q  <= '0;
            auto_view_q <= VIEW_PASS;
         end else if (trk_eof) begin
            if (auto_cnt_q == AUTO_LAST) begin
               auto_cnt_q  <= '0;
               auto_view_q <= auto_view_next;
            end else begin
               auto_cnt_q <= auto_cnt_q + AW'(1);
            end
         end
      end
   end

   assign view_sel = view_q;
   assign in_frame = (state_q == ACTIVE);

endmodule

// File: tb/tb_stereo_view_sched.sv
// Scoreboard bench for stereo_view_sched: expected view/frame/error events are
// queued as stimulus is driven and matched against DUT pulses at negedge.
module tb_stereo_view_sched;

   typedef enum int {E_LINE = 0, E_SOF = 1, E_TIMEOUT = 2} err_kind_e;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [3:0]  switch_img = 4'd0;
   logic        mon_tvalid = 1'b0;
   logic        mon_tuser = 1'b0;
   logic        mon_tlast = 1'b0;
   logic [2:0]  view_sel;
   logic        view_changed;
   logic [15:0] frame_cnt;
   logic        in_frame;
   logic        err_line;
   logic        err_sof;
   logic        err_timeout;

   int tests_run = 0;
   int tests_failed = 0;

   logic [2:0]  exp_view_q[$];
   logic [15:0] exp_frame_q[$];
   err_kind_e   exp_err_q[$];
   logic [15:0] last_frame_cnt = '0;

   always #5 aclk = ~aclk;

   stereo_view_sched #(
      .WIDTH                 (16),
      .HEIGHT                (4),
      .MAX_SAMPLES_PER_CLOCK (4),
      .NUM_VIEWS             (6),
      .AUTO_FRAMES           (2),
      .TIMEOUT_CYCLES        (8)
   ) dut (
      .aclk         (aclk),
      .areset       (areset),
      .switch_img   (switch_img),
      .mon_tvalid   (mon_tvalid),
      .mon_tuser    (mon_tuser),
      .mon_tlast    (mon_tlast),
      .view_sel     (view_sel),
      .view_changed (view_changed),
      .frame_cnt    (frame_cnt),
      .in_frame     (in_frame),
      .err_line     (err_line),
      .err_sof      (err_sof),
      .err_timeout  (err_timeout)
   );

   // Output monitor: every DUT event must match the next queued expectation.
   always @(negedge aclk) begin
      logic [2:0]  ev;
      logic [2:0]  exp_v;
      logic [15:0] exp_f;
      err_kind_e   exp_e;
      if (areset) begin
         last_frame_cnt = frame_cnt;
      end else begin
         if (view_changed) begin
            tests_run++;
            if (exp_view_q.size() == 0) begin
               tests_failed++;
               $display("FAIL view_changed: unexpected pulse with view_sel=%0d, required none", view_sel);
            end else begin
               exp_v = exp_view_q.pop_front();
               if (view_sel !== exp_v) begin
                  tests_failed++;
                  $display("FAIL view_commit: view_sel=%0d, required %0d", view_sel, exp_v);
               end
            end
         end
         if (frame_cnt !== last_frame_cnt) begin
            tests_run++;
            if (exp_frame_q.size() == 0) begin
               tests_failed++;
               $display("FAIL frame_cnt: unexpected change to %0d, required %0d", frame_cnt, last_frame_cnt);
            end else begin
               exp_f = exp_frame_q.pop_front();
               if (frame_cnt !== exp_f) begin
                  tests_failed++;
                  $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, exp_f);
               end
            end
            last_frame_cnt = frame_cnt;
         end
         ev = {err_timeout, err_sof, err_line};
         for (int k = 0; k < 3; k++) begin
            if (ev[k]) begin
               tests_run++;
               if (exp_err_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL err_pulse: unexpected error kind %0d, required none", k);
               end else begin
                  exp_e = exp_err_q.pop_front();
                  if (exp_e != err_kind_e'(k)) begin
                     tests_failed++;
                     $display("FAIL err_pulse: got error kind %0d, required kind %0d", k, int'(exp_e));
                  end
               end
            end
         end
      end
   end

   task automatic beat(input logic u, input logic l);
      mon_tvalid = 1'b1;
      mon_tuser  = u;
      mon_tlast  = l;
      @(posedge aclk);
      #1;
      mon_tvalid = 1'b0;
      mon_tuser  = 1'b0;
      mon_tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic test_reset;
      areset = 1'b1;
      switch_img = 4'd3;
      idle(3);
      tests_run++;
      if (view_sel !== 3'd0) begin
         tests_failed++; $display("FAIL reset_view: view_sel=%0d, required 0", view_sel);
      end
      tests_run++;
      if (frame_cnt !== 16'd0) begin
         tests_failed++; $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt);
      end
      tests_run++;
      if ({view_changed, in_frame, err_line, err_sof, err_timeout} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b, required 00000", {view_changed, in_frame, err_line, err_sof, err_timeout});
      end
      exp_view_q.push_back(3'd3);
      areset = 1'b0;
      idle(2);
      tests_run++;
      if (view_sel !== 3'd3) begin
         tests_failed++; $display("FAIL idle_commit: view_sel=%0d, required 3", view_sel);
      end
      tests_run++;
      if (view_changed !== 1'b0) begin
         tests_failed++; $display("FAIL changed_pulse_width: view_changed=%0b, required 0", view_changed);
      end
   endtask

   task automatic test_clean_frame;
      exp_view_q.push_back(3'd5);
      exp_frame_q.push_back(16'd1);
      for (int i = 0; i < 16; i++) begin
         if (i == 6) switch_img = 4'd5;
         beat(i == 0, (i % 4) == 3);
         if (i == 0) begin
            tests_run++;
            if (in_frame !== 1'b1) begin
               tests_failed++; $display("FAIL in_frame_sof: got %0b, required 1", in_frame);
            end
         end
         if (i < 15) begin
            tests_run++;
            if (view_sel !== 3'd3) begin
               tests_failed++; $display("FAIL no_tear beat %0d: view_sel=%0d, required 3", i, view_sel);
            end
         end
      end
      tests_run++;
      if (view_sel !== 3'd5) begin
         tests_failed++; $display("FAIL eof_commit: view_sel=%0d, required 5", view_sel);
      end
      tests_run++;
      if (in_frame !== 1'b0) begin
         tests_failed++; $display("FAIL in_frame_eof: got %0b, required 0", in_frame);
      end
   endtask

   task automatic test_line_error;
      exp_err_q.push_back(E_LINE);
      exp_frame_q.push_back(16'd2);
      for (int ln = 0; ln < 4; ln++) begin
         int n;
         n = (ln == 1) ? 3 : 4;
         for (int b = 0; b < n; b++) begin
            beat(ln == 0 && b == 0, b == n - 1);
            if (ln == 1 && b == n - 1) begin
               tests_run++;
               if (err_line !== 1'b1) begin
                  tests_failed++; $display("FAIL early_tlast: err_line=%0b, required 1", err_line);
               end
            end
         end
      end
      tests_run++;
      if (frame_cnt !== 16'd2 || in_frame !== 1'b0) begin
         tests_failed++;
         $display("FAIL line_err_frame_end: frame_cnt=%0d in_frame=%0b, required 2 and 0", frame_cnt, in_frame);
      end
   endtask

   task automatic test_sof_error;
      exp_err_q.push_back(E_SOF);
      exp_view_q.push_back(3'd1);
      exp_frame_q.push_back(16'd3);
      for (int i = 0; i < 9; i++) begin
         beat(i == 0, (i % 4) == 3);
         if (i == 0) switch_img = 4'd1;
      end
      beat(1'b1, 1'b0);
      tests_run++;
      if (err_sof !== 1'b1 || in_frame !== 1'b1) begin
         tests_failed++; $display("FAIL mid_sof: err_sof=%0b in_frame=%0b, required 1 and 1", err_sof, in_frame);
      end
      tests_run++;
      if (view_sel !== 3'd5 || frame_cnt !== 16'd2) begin
         tests_failed++; $display("FAIL mid_sof_no_commit: view_sel=%0d frame_cnt=%0d, required 5 and 2", view_sel, frame_cnt);
      end
      for (int j = 1; j < 16; j++) begin
         beat(1'b0, (j % 4) == 3);
         if (j == 14) begin
            tests_run++;
            if (in_frame !== 1'b1 || frame_cnt !== 16'd2) begin
               tests_failed++; $display("FAIL restart_span: in_frame=%0b frame_cnt=%0d, required 1 and 2", in_frame, frame_cnt);
            end
         end
      end
      tests_run++;
      if (frame_cnt !== 16'd3 || view_sel !== 3'd1) begin
         tests_failed++; $display("FAIL restart_eof: frame_cnt=%0d view_sel=%0d, required 3 and 1", frame_cnt, view_sel);
      end
   endtask

   task automatic test_timeout;
      exp_err_q.push_back(E_TIMEOUT);
      exp_view_q.push_back(3'd2);
      beat(1'b1, 1'b0);
      switch_img = 4'd2;
      for (int i = 1; i < 5; i++) beat(1'b0, (i % 4) == 3);
      idle(7);
      tests_run++;
      if (in_frame !== 1'b1 || err_timeout !== 1'b0) begin
         tests_failed++; $display("FAIL timeout_early: in_frame=%0b err_timeout=%0b, required 1 and 0", in_frame, err_timeout);
      end
      idle(1);
      tests_run++;
      if (err_timeout !== 1'b1 || in_frame !== 1'b0 || view_sel !== 3'd1) begin
         tests_failed++;
         $display("FAIL timeout_abandon: err_timeout=%0b in_frame=%0b view_sel=%0d, required 1 0 1", err_timeout, in_frame, view_sel);
      end
      idle(1);
      tests_run++;
      if (view_sel !== 3'd2 || frame_cnt !== 16'd3) begin
         tests_failed++; $display("FAIL timeout_commit: view_sel=%0d frame_cnt=%0d, required 2 and 3", view_sel, frame_cnt);
      end
   endtask

   task automatic test_auto_cycle;
      logic [2:0] seq [6];
      logic [2:0] prev;
      seq = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
      switch_img = 4'b1000;
      exp_view_q.push_back(3'd0);
      idle(2);
      tests_run++;
      if (view_sel !== 3'd0) begin
         tests_failed++; $display("FAIL auto_enter: view_sel=%0d, required 0", view_sel);
      end
      prev = 3'd0;
      for (int f = 0; f < 6; f++) begin
         exp_frame_q.push_back(16'(4 + f));
         if (seq[f] != prev) exp_view_q.push_back(seq[f]);
         prev = seq[f];
         for (int i = 0; i < 16; i++) beat(i == 0, (i % 4) == 3);
         tests_run++;
         if (view_sel !== seq[f]) begin
            tests_failed++; $display("FAIL auto_seq frame %0d: view_sel=%0d, required %0d", f, view_sel, seq[f]);
         end
         idle(2);
      end
      switch_img = 4'd7;
      exp_view_q.push_back(3'd0);
      idle(2);
      tests_run++;
      if (view_sel !== 3'd0) begin
         tests_failed++; $display("FAIL illegal_code: view_sel=%0d, required 0", view_sel);
      end
   endtask

   task automatic test_reset_midframe;
      switch_img = 4'd3;
      exp_view_q.push_back(3'd3);
      idle(2);
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b0);
      areset = 1'b1;
      idle(2);
      tests_run++;
      if (view_sel !== 3'd0 || in_frame !== 1'b0 || frame_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL midframe_reset: view_sel=%0d in_frame=%0b frame_cnt=%0d, required 0 0 0", view_sel, in_frame, frame_cnt);
      end
      exp_view_q.push_back(3'd3);
      exp_frame_q.push_back(16'd1);
      areset = 1'b0;
      idle(2);
      for (int i = 0; i < 16; i++) beat(i == 0, (i % 4) == 3);
      tests_run++;
      if (frame_cnt !== 16'd1 || view_sel !== 3'd3) begin
         tests_failed++; $display("FAIL post_reset_frame: frame_cnt=%0d view_sel=%0d, required 1 and 3", frame_cnt, view_sel);
      end
   endtask

   task automatic test_scoreboard_drained;
      idle(2);
      tests_run++;
      if (exp_view_q.size() != 0) begin
         tests_failed++; $display("FAIL view_events_missing: %0d left, required 0", exp_view_q.size());
      end
      tests_run++;
      if (exp_frame_q.size() != 0) begin
         tests_failed++; $display("FAIL frame_events_missing: %0d left, required 0", exp_frame_q.size());
      end
      tests_run++;
      if (exp_err_q.size() != 0) begin
         tests_failed++; $display("FAIL err_events_missing: %0d left, required 0", exp_err_q.size());
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_clean_frame();
      test_line_error();
      test_sof_error();
      test_timeout();
      test_auto_cycle();
      test_reset_midframe();
      test_scoreboard_drained();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

endmodule
